// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the memory-stage access controller.
package mem_access_unit_pkg;

  localparam int WORD = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10,
    MEM_D = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_REQ  = 2'b01,
    MA_WAIT = 2'b10,
    MA_DONE = 2'b11
  } ma_state_t;

  function automatic logic misaligned(input mem_size_t size, input logic [2:0] lane);
    case (size)
      MEM_B:   return 1'b0;
      MEM_H:   return lane[0];
      MEM_W:   return |lane[1:0];
      default: return |lane;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input mem_size_t size);
    case (size)
      MEM_B:   return 8'h01;
      MEM_H:   return 8'h03;
      MEM_W:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Extracts the addressed lane from a doubleword and sign/zero-extends it.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [WORD-1:0] rdata,
  input  logic [2:0]      lane,
  input  logic [1:0]      size,
  input  logic            sign_ext,
  output logic [WORD-1:0] result
);

  logic [WORD-1:0] shifted;

  always_comb begin
    shifted = rdata >> {lane, 3'b000};
    result  = shifted;
    case (mem_size_t'(size))
      MEM_B:   result = {{56{sign_ext & shifted[7]}},  shifted[7:0]};
      MEM_H:   result = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
      MEM_W:   result = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: one load or store per start over a valid/ready
// doubleword bus, with alignment faults and a response timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int SIZE    = WORD,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [1:0]      mem_size,
  input  logic            mem_signed,
  input  logic [SIZE-1:0] address,
  input  logic [SIZE-1:0] store_data,
  output logic [SIZE-1:0] read_data,
  output logic            stall,
  output logic            done,
  output logic            fault,
  output logic            bus_req,
  input  logic            bus_ready,
  output logic            bus_we,
  output logic [SIZE-1:0] bus_addr,
  output logic [SIZE-1:0] bus_wdata,
  output logic [7:0]      bus_wstrb,
  input  logic            bus_rvalid,
  input  logic [SIZE-1:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  ma_state_t       state;
  logic [CW-1:0]   wait_cnt;
  logic            is_load;
  logic [1:0]      lat_size;
  logic            lat_signed;
  logic [2:0]      lat_lane;
  logic [2:0]      lane;
  logic            req_bad;
  logic [SIZE-1:0] load_value;

  always_comb begin
    lane    = address[2:0];
    req_bad = (mem_read == mem_write) | misaligned(mem_size_t'(mem_size), lane);
  end

  assign stall = ((state == MA_IDLE) && start) || (state == MA_REQ) || (state == MA_WAIT);

  load_align u_load_align (
    .rdata    (bus_rdata),
    .lane     (lat_lane),
    .size     (lat_size),
    .sign_ext (lat_signed),
    .result   (load_value)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= MA_IDLE;
      read_data  <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_wstrb  <= '0;
      wait_cnt   <= '0;
      is_load    <= 1'b0;
      lat_size   <= '0;
      lat_signed <= 1'b0;
      lat_lane   <= '0;
    end else begin
      case (state)
        MA_IDLE: begin
          if (start) begin
            if (req_bad) begin
              fault <= 1'b1;
              done  <= 1'b1;
              state <= MA_DONE;
            end else begin
              bus_req    <= 1'b1;
              bus_we     <= mem_write;
              bus_addr   <= {address[SIZE-1:3], 3'b000};
              bus_wdata  <= store_data << {lane, 3'b000};
              bus_wstrb  <= byte_mask(mem_size_t'(mem_size)) << lane;
              is_load    <= mem_read;
              lat_size   <= mem_size;
              lat_signed <= mem_signed;
              lat_lane   <= lane;
              state      <= MA_REQ;
            end
          end
        end
        MA_REQ: begin
          if (bus_ready) begin
            bus_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= MA_WAIT;
          end
        end
        MA_WAIT: begin
          // A response arriving on the final counted cycle still completes normally.
          if (bus_rvalid) begin
            if (is_load) read_data <= load_value;
            done  <= 1'b1;
            state <= MA_DONE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            fault <= 1'b1;
            done  <= 1'b1;
            state <= MA_DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        MA_DONE: begin
          done  <= 1'b0;
          fault <= 1'b0;
          state <= MA_IDLE;
        end
        default: state <= MA_IDLE;
      endcase
    end
  end

endmodule
